// File: rtl/dice_hand_sampler.sv
// dice_hand_sampler: debounces a roll button, draws three dice (1..6) from a
// free-running Galois LFSR by rejection sampling, and offers the hand to the
// downstream detector over a valid/ready handshake. The hand stays frozen
// until the detector accepts it.
module dice_hand_sampler #(
  parameter int unsigned MAX_COUNT  = 10000,
  parameter logic [15:0] LFSR_RESET = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       roll_btn,
  input  logic       seed_load,
  input  logic [7:0] seed,
  output logic       hand_valid,
  input  logic       hand_ready,
  output logic [2:0] die0,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic       busy
);

  localparam logic [15:0] CNT_LAST  = 16'(MAX_COUNT - 32'd1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    VALID = 2'd2
  } state_t;

  // One right-shift step of the Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;
  logic [15:0] lfsr_q, lfsr_d;
  state_t      state_q;
  logic [1:0]  idx_q;
  logic [2:0]  die0_q, die1_q, die2_q;
  logic        valid_q, busy_q;
  logic [2:0]  roll_r_s;
  logic        accept_s;

  // Debounce next state: count consecutive disagreeing samples, flip on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = ~deb_q;
        cnt_d   = 16'h0000;
        press_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 16'h0001;
      end
    end else begin
      cnt_d = 16'h0000;
    end
  end

  // LFSR next state: a seed load is honoured only while idle and wins over the shift.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if ((state_q == IDLE) && seed_load) begin
      lfsr_d = {seed, ~seed};
    end else begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Candidate die value comes from the LFSR before this cycle's shift; 0 and 7 are rejected.
  always_comb begin
    roll_r_s = lfsr_q[2:0];
    accept_s = (lfsr_q[2:0] != 3'd0) && (lfsr_q[2:0] != 3'd7);
  end

  // Input synchronizer, debounce counter, press pulse and LFSR, all frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= 16'h0000;
      press_q <= 1'b0;
      lfsr_q  <= LFSR_RESET;
    end else if (ena) begin
      sync1_q <= roll_btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Hand FSM with registered dice, hand_valid and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      die0_q  <= 3'd0;
      die1_q  <= 3'd0;
      die2_q  <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (press_q) begin
            state_q <= ROLL;
            idx_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        ROLL: begin
          if (accept_s) begin
            case (idx_q)
              2'd0:    die0_q <= roll_r_s;
              2'd1:    die1_q <= roll_r_s;
              default: die2_q <= roll_r_s;
            endcase
            if (idx_q == 2'd2) begin
              state_q <= VALID;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        VALID: begin
          if (hand_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 2'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hand_valid = valid_q;
  assign busy       = busy_q;
  assign die0       = die0_q;
  assign die1       = die1_q;
  assign die2       = die2_q;

endmodule

// File: tb/tb_dice_hand_sampler.sv
// Self-checking bench for dice_hand_sampler with a short debounce (MAX_COUNT = 4).
module tb_dice_hand_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       roll_btn;
  logic       seed_load;
  logic [7:0] seed;
  logic       hand_valid;
  logic       hand_ready;
  logic [2:0] die0, die1, die2;
  logic       busy;

  dice_hand_sampler #(.MAX_COUNT(4), .LFSR_RESET(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .roll_btn(roll_btn),
    .seed_load(seed_load), .seed(seed), .hand_valid(hand_valid),
    .hand_ready(hand_ready), .die0(die0), .die1(die1), .die2(die2), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference LFSR, stepped on every clock edge the DUT is enabled and out of reset.
  logic [15:0] m_lfsr;
  logic        m_load;
  logic [7:0]  m_seed;

  typedef struct {
    int width;     // roll_btn high cycles
    int exp_rise;  // expected ticks until busy rises, 0 = never
  } glitch_vec_t;

  glitch_vec_t tbl[5];

  function automatic logic [15:0] model_step(input logic [15:0] x);
    logic [15:0] nx;
    nx = {1'b0, x[15:1]};
    if (x[0]) nx = nx ^ 16'hB400;
    return nx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && ena) begin
      if (m_load) m_lfsr = {m_seed, ~m_seed};
      else        m_lfsr = model_step(m_lfsr);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Predict the dice and the ROLL length from the LFSR value at ROLL entry.
  task automatic model_roll(input logic [15:0] s, output logic [2:0] d0, output logic [2:0] d1,
                            output logic [2:0] d2, output int len);
    logic [15:0] x;
    logic [2:0]  r;
    int          i;
    x = s; i = 0; len = 0; d0 = 3'd0; d1 = 3'd0; d2 = 3'd0;
    while (i < 3 && len < 1000) begin
      r = x[2:0];
      if (r >= 3'd1 && r <= 3'd6) begin
        if (i == 0) d0 = r;
        else if (i == 1) d1 = r;
        else d2 = r;
        i++;
      end
      x = model_step(x);
      len++;
    end
  endtask

  // Raise the button (drop it after 'width' ticks, 0 = until busy) and report when busy rises.
  task automatic press(input int width, output int rise);
    roll_btn = 1'b1;
    rise = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == width) roll_btn = 1'b0;
      if (busy) begin
        rise = t;
        break;
      end
    end
    roll_btn = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!hand_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Let the model predict the hand from the current LFSR, then check length and dice.
  task automatic roll_check(input string tag, output logic [2:0] e0, output logic [2:0] e1,
                            output logic [2:0] e2, output int len);
    int n;
    model_roll(m_lfsr, e0, e1, e2, len);
    wait_valid(n);
    chk({tag, "_len"}, n, len);
    chk({tag, "_die0"}, die0, e0);
    chk({tag, "_die1"}, die1, e1);
    chk({tag, "_die2"}, die2, e2);
  endtask

  task automatic accept(input string tag);
    hand_ready = 1'b1;
    tick();
    hand_ready = 1'b0;
    chk({tag, "_acc_valid"}, hand_valid, 1'b0);
    chk({tag, "_acc_busy"}, busy, 1'b0);
  endtask

  initial begin
    int rise, n, len, ref_len;
    logic [2:0] e0, e1, e2, r0, r1, r2, h0, h1, h2;
    logic bad;

    rst_n = 1'b0; ena = 1'b1; roll_btn = 1'b0; seed_load = 1'b0; seed = 8'h00;
    hand_ready = 1'b0; m_lfsr = 16'hACE1; m_load = 1'b0; m_seed = 8'h00;

    tbl[0] = '{1, 0};
    tbl[1] = '{2, 0};
    tbl[2] = '{3, 0};
    tbl[3] = '{4, 7};
    tbl[4] = '{5, 7};

    idle(3);
    chk("rst_die0", die0, 3'd0);
    chk("rst_die1", die1, 3'd0);
    chk("rst_die2", die2, 3'd0);
    chk("rst_valid", hand_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Glitch widths below MAX_COUNT never press; width >= MAX_COUNT presses after MAX_COUNT+2.
    for (int v = 0; v < 5; v++) begin
      press(tbl[v].width, rise);
      chk($sformatf("glitch_w%0d_rise", tbl[v].width), rise, tbl[v].exp_rise);
      if (rise != 0) begin
        roll_check($sformatf("glitch_w%0d", tbl[v].width), e0, e1, e2, len);
        accept($sformatf("glitch_w%0d", tbl[v].width));
      end
      idle(10);
    end

    // Bounce: high 3, low 2, high 3 must not press.
    bad = 1'b0;
    for (int t = 0; t < 25; t++) begin
      roll_btn = (t < 3) || (t >= 5 && t < 8);
      tick();
      if (busy) bad = 1'b1;
    end
    chk("bounce_busy", bad, 1'b0);
    press(0, rise);
    chk("bounce_hold_rise", rise, 7);
    roll_check("bp", h0, h1, h2, len);

    // Backpressure with a dropped press and an ignored seed_load during VALID.
    bad = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 3) roll_btn = 1'b1;
      if (t == 11) roll_btn = 1'b0;
      seed_load = (t == 5);
      seed = 8'h5A;
      tick();
      if (!hand_valid || !busy || die0 != h0 || die1 != h1 || die2 != h2) bad = 1'b1;
    end
    seed_load = 1'b0;
    chk("bp_stable", bad, 1'b0);
    accept("bp");
    bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (busy) bad = 1'b1;
    end
    chk("bp_press_dropped", bad, 1'b0);

    // Next roll follows the unloaded LFSR trajectory.
    press(0, rise);
    chk("noload_rise", rise, 7);
    roll_check("noload", e0, e1, e2, len);
    accept("noload");
    idle(10);

    // Seed 8'h00 gives lfsr 16'h00FF at ROLL entry: hand 3,1,4 after 10 ROLL cycles.
    seed_load = 1'b1; seed = 8'h00; m_load = 1'b1; m_seed = 8'h00;
    press(0, rise);
    seed_load = 1'b0; m_load = 1'b0;
    chk("seed_rise", rise, 7);
    wait_valid(n);
    chk("seed_len", n, 10);
    chk("seed_die0", die0, 3'd3);
    chk("seed_die1", die1, 3'd1);
    chk("seed_die2", die2, 3'd4);
    accept("seed");
    idle(10);

    // Asynchronous reset in the middle of ROLL.
    press(0, rise);
    chk("rstroll_rise", rise, 7);
    idle(2);
    rst_n = 1'b0;
    m_lfsr = 16'hACE1;
    #2;
    chk("rstroll_die0", die0, 3'd0);
    chk("rstroll_die1", die1, 3'd0);
    chk("rstroll_die2", die2, 3'd0);
    chk("rstroll_valid", hand_valid, 1'b0);
    chk("rstroll_busy", busy, 1'b0);
    idle(2);
    rst_n = 1'b1;
    press(0, rise);
    chk("restart_rise", rise, 7);
    roll_check("restart", r0, r1, r2, ref_len);
    accept("restart");

    // Same restart with ena low for 5 cycles during ROLL.
    rst_n = 1'b0;
    m_lfsr = 16'hACE1;
    idle(2);
    rst_n = 1'b1;
    press(0, rise);
    chk("ena_rise", rise, 7);
    idle(2);
    ena = 1'b0;
    bad = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (!busy || hand_valid) bad = 1'b1;
    end
    ena = 1'b1;
    chk("ena_hold", bad, 1'b0);
    wait_valid(n);
    chk("ena_len_after_resume", n, ref_len - 2);
    chk("ena_die0", die0, r0);
    chk("ena_die1", die1, r1);
    chk("ena_die2", die2, r2);
    accept("ena");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_hand_sampler.md
# dice_hand_sampler

Upstream stage of the pair/triple detector. Debounces a raw roll button, draws three dice values (1..6) from a free-running 16-bit LFSR using rejection sampling, and presents the hand to the detector over a valid/ready handshake. The hand is held stable until the detector accepts it.

## Interface

Parameters:
- MAX_COUNT, 10000: debounce length, in consecutive cycles. Legal range 2..65535; the counter is 16 bits.
- LFSR_RESET, 16'hACE1: LFSR value after reset. Must be non-zero.

Ports:
- clk  in  1  system clock; the block uses only this clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  enable. When low, every register holds its value, including the synchronizer, debounce counter, LFSR and FSM.
- roll_btn  in  1  raw button input. It is asynchronous and may bounce.
- seed_load  in  1  when high in IDLE, loads the LFSR from seed.
- seed  in  8  seed value.
- hand_valid  out  1  a hand is presented.
- hand_ready  in  1  the detector accepts the hand.
- die0, die1, die2  out  3 each  dice values 1..6; value 0 only after reset.
- busy  out  1  high when the FSM is not in IDLE.

## Operation

- Synchronizer: two flops, sync1 then sync2, on roll_btn. Both reset to 0.
- Debounce:
  - deb_level resets to 0. cnt is 16 bits and resets to 0.
  - When sync2 differs from deb_level, cnt increments.
  - When sync2 equals deb_level, cnt clears.
  - When sync2 differs and cnt equals MAX_COUNT-1: deb_level flips and cnt clears.
  - A press is the flip of deb_level from 0 to 1. A release (flip 1 to 0) has no effect.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifting right.
  - Update rule: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances on every enabled cycle in every state.
  - seed_load in IDLE sets lfsr <= {seed, ~seed}. This value is never zero. The load takes priority over the shift.
  - seed_load in any other state is ignored.
- FSM states: IDLE, ROLL, VALID.
  - IDLE: a press moves to ROLL and clears the die index idx to 0. The dice outputs keep their old values.
  - ROLL: each cycle, sample r = lfsr[2:0], taken before this cycle's shift.
    - If 1 <= r <= 6: write r to die[idx] and increment idx.
    - If r is 0 or 7: reject it; idx is unchanged.
    - On the third accept, move to VALID.
  - VALID: hand_valid = 1 and die0..2 are frozen. When hand_valid and hand_ready are both high at a clock edge, move to IDLE.
  - A press in ROLL or VALID is dropped; it is not queued.
- Outputs:
  - hand_valid is registered and is high exactly in VALID.
  - busy = (state != IDLE), registered.
- Reset: asynchronous assertion in any state forces, immediately:
  - state IDLE, idx 0;
  - die0..2 = 0, hand_valid 0, busy 0;
  - lfsr = LFSR_RESET, cnt 0, sync1/sync2/deb_level 0.
  - A hand in flight is discarded. Deassertion is taken synchronously by the next clock edge.

## Timing

- Roll_btn rises and stays high, and edge E is the first edge at which sync1 samples 1:
  - sync2 = 1 after E+1;
  - deb_level = 1 after edge E+1+MAX_COUNT;
  - the FSM enters ROLL, and busy rises, at edge E+2+MAX_COUNT.
- ROLL length = 3 + number of rejects. Minimum 3 cycles. No upper bound is specified, but the LFSR is maximal-length, so the roll always completes.
- hand_valid rises on the same edge that writes die2.
- After the accepting edge (valid & ready): hand_valid = 0 and busy = 0. A new press can start ROLL at the next edge.
- hand_ready while not in VALID is ignored.
- A glitch shorter than MAX_COUNT consecutive sync2 cycles never changes deb_level.
- ena low for N cycles stretches every latency above by exactly N cycles.

## Test plan

- Reset values: assert rst_n = 0 mid-ROLL with MAX_COUNT = 4 → immediately die0..2 = 0, hand_valid = 0, busy = 0; after release, the LFSR sequence restarts from 16'hACE1.
- Bounce rejection, MAX_COUNT = 4: hold roll_btn high 3 cycles, low 2, high 3 → busy stays 0. Then hold high 10 cycles → busy rises exactly MAX_COUNT+2 = 6 edges after sync1 first samples the 1.
- Determinism: seed_load with seed = 8'h00 (lfsr = 16'h00FF), then press → die0..2 and the ROLL length match a bit-exact model of the Galois LFSR; all dice are in 1..6.
- Backpressure: hold hand_ready = 0 for 20 cycles in VALID and press again → hand_valid stays 1, dice unchanged, press dropped. Raise hand_ready for 1 cycle → hand_valid = 0 and busy = 0 at the next edge.
- ena gating: pull ena = 0 for 5 cycles in the middle of ROLL → lfsr, idx and dice hold their values; after resume, the outputs equal the ungated run delayed by 5 cycles.
- seed_load ignored: pulse seed_load = 1, seed = 8'h5A during VALID → the lfsr trajectory is unaffected and matches the no-load model.
